// File: rtl/axis_adc4_dec_pkg.sv
// axis_adc4_dec_pkg
//   Shared constants and types for the 4-lane ADC block-averaging decimator.
//   NCH          : number of ADC lanes packed into one 64-bit beat
//   SAMPLE_W     : width of one signed lane sample (14-bit data, sign-extended)
//   LOG2_MAX_DEF : default largest decimation exponent L
package axis_adc4_dec_pkg;

  localparam int unsigned NCH          = 4;
  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned LOG2_MAX_DEF = 10;

  typedef logic signed [SAMPLE_W-1:0]              sample_t;
  typedef logic signed [SAMPLE_W+LOG2_MAX_DEF-1:0] acc_t;
  typedef sample_t                                 lanes_t [NCH];

  // Programmed exponent limited to what the accumulators can hold.
  function automatic int unsigned clamp_log2(input int unsigned l, input int unsigned lmax);
    return (l > lmax) ? lmax : l;
  endfunction

endpackage

// File: rtl/axis_adc4_dec_lane.sv
// axis_adc4_dec_lane
//   One lane's accumulate / clear / shift datapath.
//   aclk, aresetn : clock, asynchronous active-low reset
//   clear         : synchronous clear of the accumulator (block disabled)
//   beat          : accepted input beat this cycle
//   last          : this beat closes the current window
//   lw            : exponent of the current window
//   sample        : this lane's signed input sample
//   mean          : (acc + sample) >>> lw, valid when beat & last
module axis_adc4_dec_lane
  import axis_adc4_dec_pkg::*;
#(
  parameter int unsigned LOG2_MAX = LOG2_MAX_DEF,
  parameter int unsigned LW_W     = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            clear,
  input  logic            beat,
  input  logic            last,
  input  logic [LW_W-1:0] lw,
  input  sample_t         sample,
  output sample_t         mean
);

  localparam int unsigned ACC_W = SAMPLE_W + LOG2_MAX;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  // The final beat is folded in combinationally so the mean is ready at the
  // same edge that closes the window.
  assign sum  = acc + ACC_W'(sample);
  assign mean = sample_t'(sum >>> lw);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (beat) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/axis_adc4_decimator.sv
// axis_adc4_decimator
//   Block-averages 4 signed 16-bit ADC lanes over 2^L beats and emits the
//   4 means on an AXI4-Stream master. Results that meet a stalled output are
//   dropped and counted, never queued.
//   aclk, aresetn     : clock, asynchronous active-low reset
//   cfg_enable        : 0 = clear and idle, 1 = run
//   cfg_log2          : L (clamped to LOG2_MAX), latched at each window start
//   cfg_clear_sts     : pulse clearing sts_overrun / sts_drop_cnt
//   s_axis_*          : input beats (tready tied 1)
//   m_axis_*          : output means, lane k in bits [16k+15:16k]
//   sts_overrun       : sticky, at least one result dropped
//   sts_drop_cnt      : saturating dropped-result count
//   Optional macro AXIS_ADC4_DEC_TLAST_EN adds FRAME_LEN and m_axis_tlast,
//   asserted on every FRAME_LEN-th delivered result.
module axis_adc4_decimator
  import axis_adc4_dec_pkg::*;
#(
  parameter int unsigned LOG2_MAX   = LOG2_MAX_DEF,
  parameter int unsigned DROP_CNT_W = 16
`ifdef AXIS_ADC4_DEC_TLAST_EN
  ,
  parameter int unsigned FRAME_LEN  = 1024
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_log2,
  input  logic                  cfg_clear_sts,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_ADC4_DEC_TLAST_EN
  output logic                  m_axis_tlast,
`endif
  output logic                  sts_overrun,
  output logic [DROP_CNT_W-1:0] sts_drop_cnt
);

  localparam int unsigned LW_W  = $clog2(LOG2_MAX + 1);
  localparam int unsigned CNT_W = LOG2_MAX + 1;

  logic [LW_W-1:0]  lw_q;
  logic [LW_W-1:0]  l_cfg;
  logic [LW_W-1:0]  lw_cur;
  logic [CNT_W-1:0] cnt;
  logic             beat;
  logic             last;
  logic             res_valid;
  logic             hs;
  logic             out_free;
  logic             drop;
  lanes_t           samples;
  lanes_t           means;

  assign s_axis_tready = 1'b1;

  // The first beat of a window uses the freshly programmed L, so L = 0
  // windows close on the same beat that opens them.
  always_comb begin
    l_cfg  = LW_W'(clamp_log2(32'(cfg_log2), LOG2_MAX));
    lw_cur = (cnt == '0) ? l_cfg : lw_q;
    last   = ((cnt + 1'b1) == (CNT_W'(1) << lw_cur));
  end

  assign beat      = s_axis_tvalid & cfg_enable;
  assign res_valid = beat & last;
  assign hs        = m_axis_tvalid & m_axis_tready;
  assign out_free  = ~m_axis_tvalid | m_axis_tready;
  assign drop      = res_valid & ~out_free;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt  <= '0;
      lw_q <= '0;
    end else if (!cfg_enable) begin
      cnt <= '0;
    end else if (beat) begin
      if (cnt == '0) lw_q <= l_cfg;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign samples[k] = s_axis_tdata[SAMPLE_W*k +: SAMPLE_W];

    axis_adc4_dec_lane #(
      .LOG2_MAX (LOG2_MAX),
      .LW_W     (LW_W)
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (~cfg_enable),
      .beat    (beat),
      .last    (last),
      .lw      (lw_cur),
      .sample  (samples[k]),
      .mean    (means[k])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (res_valid && out_free) begin
      m_axis_tvalid <= 1'b1;
      for (int unsigned k = 0; k < NCH; k++) begin
        m_axis_tdata[SAMPLE_W*k +: SAMPLE_W] <= means[k];
      end
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // A drop coinciding with a clear restarts the count at 1.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_overrun  <= 1'b0;
      sts_drop_cnt <= '0;
    end else if (drop) begin
      sts_overrun <= 1'b1;
      if (cfg_clear_sts)      sts_drop_cnt <= DROP_CNT_W'(1);
      else if (~&sts_drop_cnt) sts_drop_cnt <= sts_drop_cnt + 1'b1;
    end else if (cfg_clear_sts) begin
      sts_overrun  <= 1'b0;
      sts_drop_cnt <= '0;
    end
  end

`ifdef AXIS_ADC4_DEC_TLAST_EN
  localparam int unsigned FR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FR_W-1:0] frame_cnt;

  // frame_cnt counts completed handshakes; it is stable while a result is
  // held, so tlast can be decoded from it directly.
  assign m_axis_tlast = m_axis_tvalid && (frame_cnt == FR_W'(FRAME_LEN - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= '0;
    end else if (!cfg_enable) begin
      frame_cnt <= '0;
    end else if (hs) begin
      frame_cnt <= (frame_cnt == FR_W'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  // Untagged stream: no frame tracking.
`endif

endmodule
